// File: rtl/qnigma_math_pkg.sv
// Shared arithmetic helpers for the qnigma averaging path: sum width,
// width-parameterised sign extension and the rounding arithmetic shift.
package qnigma_math_pkg;

    localparam int MATH_W = 64;

    typedef logic [MATH_W-1:0] wide_t;

    function automatic int sumw(input int w, input int n, input int k);
        return w + n + k;
    endfunction

    // Extend the low w bits of v to the full helper width.
    function automatic wide_t sext(input wide_t v, input int w, input bit sgn);
        wide_t r;
        r = {MATH_W{1'b0}};
        for (int i = 0; i < MATH_W; i++) begin
            if (i < w) begin
                r[i] = v[i];
            end else if (sgn) begin
                r[i] = v[w-1];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // The wide helper width is the guard bit: adding the half never wraps.
    function automatic wide_t round_shift(input wide_t v, input int sh, input bit sgn, input bit rnd);
        wide_t b;
        if (rnd && sh > 0) begin
            b = v + (64'd1 << (sh - 1));
        end else begin
            b = v;
        end
        if (sgn) begin
            return wide_t'($signed(b) >>> sh);
        end else begin
            return b >> sh;
        end
    endfunction

endpackage

// File: rtl/qnigma_sum_tree.sv
// Pipelined, valid-carrying adder tree: one registered pair-add stage per
// level, recursing on the half-width result until a single lane remains.
module qnigma_sum_tree
    import qnigma_math_pkg::*;
#(
    parameter int W      = 8,
    parameter int N      = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_val,
    input  logic [2**N-1:0][W-1:0]  in_dat,
    output logic                    out_val,
    output logic [W+N-1:0]          out_sum
);

    localparam int HALF = 2**(N-1);

    logic [HALF-1:0][W:0] pair_r;
    logic                 pair_val_r;

    // Stage valid flag, flushed by reset and clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_val_r <= 1'b0;
        end else if (clr) begin
            pair_val_r <= 1'b0;
        end else begin
            pair_val_r <= in_val;
        end
    end

    // Pair sums at one extra bit; data only moves with a valid beat.
    always_ff @(posedge clk) begin
        if (in_val) begin
            for (int i = 0; i < HALF; i++) begin
                pair_r[i] <= (W+1)'(sext(wide_t'(in_dat[2*i]), W, SIGNED)
                                  + sext(wide_t'(in_dat[2*i+1]), W, SIGNED));
            end
        end
    end

    generate
        if (N == 1) begin : g_leaf
            assign out_val = pair_val_r;
            assign out_sum = pair_r[0];
        end else begin : g_next
            qnigma_sum_tree #(
                .W      (W + 1),
                .N      (N - 1),
                .SIGNED (SIGNED)
            ) u_next (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr     (clr),
                .in_val  (pair_val_r),
                .in_dat  (pair_r),
                .out_val (out_val),
                .out_sum (out_sum)
            );
        end
    endgenerate

endmodule

// File: rtl/qnigma_avg.sv
// Streaming block averager: input capture, lane adder tree, then a beat
// accumulator emitting the full-precision block sum and its rounded average.
module qnigma_avg
    import qnigma_math_pkg::*;
#(
    parameter int W      = 8,
    parameter int N      = 2,
    parameter int K      = 2,
    parameter bit SIGNED = 1'b0,
    parameter bit ROUND  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_val,
    input  logic [2**N-1:0][W-1:0]  in_dat,
    output logic                    res_val,
    output logic [W+N+K-1:0]        res,
    output logic [W-1:0]            avg,
    output logic [K:0]              cnt
);

    localparam int         SW       = sumw(W, N, K);
    localparam logic [K:0] CNT_LAST = (K+1)'(2**K - 1);

    logic                   in_val_r;
    logic [2**N-1:0][W-1:0] in_dat_r;
    logic                   tree_val_s;
    logic [W+N-1:0]         tree_sum_s;
    logic [SW-1:0]          tree_ext_s;
    logic [SW-1:0]          acc_next_s;
    logic                   last_s;
    logic [SW-1:0]          acc_r;
    logic [K:0]             cnt_r;
    logic                   res_val_r;
    logic [SW-1:0]          res_r;
    logic [W-1:0]           avg_r;

    // Input capture valid; a beat coincident with clr is dropped here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_val_r <= 1'b0;
        end else if (clr) begin
            in_val_r <= 1'b0;
        end else begin
            in_val_r <= in_val;
        end
    end

    // Input capture data.
    always_ff @(posedge clk) begin
        if (in_val) begin
            in_dat_r <= in_dat;
        end
    end

    qnigma_sum_tree #(
        .W      (W),
        .N      (N),
        .SIGNED (SIGNED)
    ) u_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .in_val  (in_val_r),
        .in_dat  (in_dat_r),
        .out_val (tree_val_s),
        .out_sum (tree_sum_s)
    );

    // Next accumulator value; the first beat of a block overwrites.
    always_comb begin
        tree_ext_s = SW'(sext(wide_t'(tree_sum_s), W + N, SIGNED));
        if (cnt_r == {(K+1){1'b0}}) begin
            acc_next_s = tree_ext_s;
        end else begin
            acc_next_s = acc_r + tree_ext_s;
        end
        last_s = (cnt_r == CNT_LAST);
    end

    // Accumulator, beat counter and result registers; clr beats a final beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r     <= {SW{1'b0}};
            cnt_r     <= {(K+1){1'b0}};
            res_val_r <= 1'b0;
            res_r     <= {SW{1'b0}};
            avg_r     <= {W{1'b0}};
        end else if (clr) begin
            acc_r     <= {SW{1'b0}};
            cnt_r     <= {(K+1){1'b0}};
            res_val_r <= 1'b0;
        end else if (tree_val_s) begin
            if (last_s) begin
                acc_r     <= {SW{1'b0}};
                cnt_r     <= {(K+1){1'b0}};
                res_val_r <= 1'b1;
                res_r     <= acc_next_s;
                avg_r     <= W'(round_shift(sext(wide_t'(acc_next_s), SW, SIGNED),
                                            N + K, SIGNED, ROUND));
            end else begin
                acc_r     <= acc_next_s;
                cnt_r     <= cnt_r + (K+1)'(1);
                res_val_r <= 1'b0;
            end
        end else begin
            res_val_r <= 1'b0;
        end
    end

    assign res_val = res_val_r;
    assign res     = res_r;
    assign avg     = avg_r;
    assign cnt     = cnt_r;

endmodule

// File: tb/tb_qnigma_avg.sv
// Bench for qnigma_avg: four configurations share one stimulus stream and are
// checked against a time-keyed block-sum reference model.
module tb_qnigma_avg;

    localparam int TN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n  = 1'b0;
    logic            clr    = 1'b0;
    logic            in_val = 1'b0;
    logic [3:0][7:0] in_dat = 32'h0;

    logic        res_val0, res_val1, res_val2, res_val3;
    logic [11:0] res0, res1, res2;
    logic [9:0]  res3;
    logic [7:0]  avg0, avg1, avg2, avg3;
    logic [2:0]  cnt0, cnt1, cnt2;
    logic [0:0]  cnt3;

    qnigma_avg #(.W(8), .N(TN), .K(2), .SIGNED(1'b0), .ROUND(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_val(in_val), .in_dat(in_dat),
        .res_val(res_val0), .res(res0), .avg(avg0), .cnt(cnt0));
    qnigma_avg #(.W(8), .N(TN), .K(2), .SIGNED(1'b1), .ROUND(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_val(in_val), .in_dat(in_dat),
        .res_val(res_val1), .res(res1), .avg(avg1), .cnt(cnt1));
    qnigma_avg #(.W(8), .N(TN), .K(2), .SIGNED(1'b0), .ROUND(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_val(in_val), .in_dat(in_dat),
        .res_val(res_val2), .res(res2), .avg(avg2), .cnt(cnt2));
    qnigma_avg #(.W(8), .N(TN), .K(0), .SIGNED(1'b0), .ROUND(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_val(in_val), .in_dat(in_dat),
        .res_val(res_val3), .res(res3), .avg(avg3), .cnt(cnt3));

    logic        rv [4];
    logic [15:0] rs [4];
    logic [7:0]  av [4];
    logic [2:0]  cn [4];
    assign rv[0] = res_val0;   assign rv[1] = res_val1;
    assign rv[2] = res_val2;   assign rv[3] = res_val3;
    assign rs[0] = 16'(res0);  assign rs[1] = 16'(res1);
    assign rs[2] = 16'(res2);  assign rs[3] = 16'(res3);
    assign av[0] = avg0;       assign av[1] = avg1;
    assign av[2] = avg2;       assign av[3] = avg3;
    assign cn[0] = cnt0;       assign cn[1] = cnt1;
    assign cn[2] = cnt2;       assign cn[3] = 3'(cnt3);

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: beats keyed by the edge at which they join the block.
    longint pend_u [longint];
    longint pend_s [longint];
    longint edge_n = 0;
    longint bsum [4] = '{4{64'sd0}};
    int     bcnt [4] = '{4{0}};
    bit     exp_val [4] = '{4{1'b0}};
    longint exp_res [4] = '{4{64'sd0}};
    longint exp_avg [4] = '{4{64'sd0}};
    bit     chk_val [4];
    longint chk_res [4];
    longint chk_avg [4];
    int     chk_cnt [4];

    function automatic int kof(input int d);
        return (d == 3) ? 0 : 2;
    endfunction

    function automatic longint wmask(input int d);
        return (longint'(1) << (8 + TN + kof(d))) - 64'sd1;
    endfunction

    function automatic longint avg_ref(input longint s, input int d);
        longint div, v;
        div = longint'(1) << (TN + kof(d));
        v = (d != 2) ? s + div / 2 : s;
        if (v >= 0) return v / div;
        else return -((-v + div - 1) / div);
    endfunction

    // One clock of stimulus; the model predicts the outputs after the next edge.
    task automatic apply(input logic v, input logic [31:0] dat, input logic c, input logic rn);
        longint su, ss, x;
        logic signed [7:0] t8;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk_val[d] = exp_val[d];
            chk_res[d] = exp_res[d];
            chk_avg[d] = exp_avg[d];
            chk_cnt[d] = bcnt[d];
        end
        in_val = v; in_dat = dat; clr = c; rst_n = rn;
        su = 0; ss = 0;
        for (int l = 0; l < 4; l++) begin
            t8 = dat[8*l +: 8];
            su += longint'(dat[8*l +: 8]);
            ss += longint'(t8);
        end
        for (int d = 0; d < 4; d++) exp_val[d] = 1'b0;
        if (!rn || c) begin
            pend_u.delete();
            pend_s.delete();
            for (int d = 0; d < 4; d++) begin
                bsum[d] = 0;
                bcnt[d] = 0;
                if (!rn) begin
                    exp_res[d] = 0;
                    exp_avg[d] = 0;
                end
            end
        end else begin
            if (pend_u.exists(edge_n)) begin
                for (int d = 0; d < 4; d++) begin
                    x = (d == 1) ? pend_s[edge_n] : pend_u[edge_n];
                    bsum[d] += x;
                    bcnt[d]++;
                    if (bcnt[d] == (1 << kof(d))) begin
                        exp_val[d] = 1'b1;
                        exp_res[d] = bsum[d];
                        exp_avg[d] = avg_ref(bsum[d], d);
                        bsum[d] = 0;
                        bcnt[d] = 0;
                    end
                end
                pend_u.delete(edge_n);
                pend_s.delete(edge_n);
            end
            if (v) begin
                pend_u[edge_n + TN + 1] = su;
                pend_s[edge_n + TN + 1] = ss;
            end
        end
        edge_n++;
    endtask

    // Flushes, sends one 4-beat block and captures the first dut0 pulse.
    task automatic run_block(input logic [3:0][31:0] blk, input int gap,
                             output bit seen, output int lat, output int extra,
                             output logic [2:0][15:0] r, output logic [2:0][7:0] a);
        apply(1'b0, $urandom, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) begin
            apply(1'b1, blk[b], 1'b0, 1'b1);
            if (b < 3) for (int g = 0; g < gap; g++) apply(1'b0, $urandom, 1'b0, 1'b1);
        end
        seen = 1'b0; lat = -1; extra = 0; r = '0; a = '0;
        for (int c = 1; c <= 12; c++) begin
            apply(1'b0, $urandom, 1'b0, 1'b1);
            if (rv[0] === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    lat = c - 1;
                    for (int d = 0; d < 3; d++) begin
                        r[d] = rs[d];
                        a[d] = av[d];
                    end
                end else begin
                    extra++;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        for (int d = 0; d < 4; d++) begin
            n_vec++;
            if (rv[d] !== 1'b0 || rs[d] !== 16'h0 || av[d] !== 8'h0 || cn[d] !== 3'h0) begin
                n_err++;
                $display("FAIL reset dut%0d: got val=%b res=%h avg=%h cnt=%0d, want all 0", d, rv[d], rs[d], av[d], cn[d]);
            end
        end
        apply(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_plan_blocks();
        bit seen; int lat, extra;
        logic [2:0][15:0] r; logic [2:0][7:0] a;
        run_block({4{32'h01010101}}, 0, seen, lat, extra, r, a);
        n_vec++;
        if (!seen || lat != TN + 1 || extra != 0 || r[0] !== 16'd16 || a[0] !== 8'd1) begin
            n_err++;
            $display("FAIL ones: got seen=%b lat=%0d extra=%0d res=%0d avg=%0d, want 1 3 0 16 1", seen, lat, extra, r[0], a[0]);
        end
        run_block({4{32'hFFFFFFFF}}, 2, seen, lat, extra, r, a);
        n_vec++;
        if (!seen || extra != 0 || r[0] !== 16'd4080 || a[0] !== 8'd255) begin
            n_err++;
            $display("FAIL max_gaps: got seen=%b extra=%0d res=%0d avg=%0d, want 1 0 4080 255", seen, extra, r[0], a[0]);
        end
        n_vec++;
        if (r[1] !== 16'h0FF0 || a[1] !== 8'hFF) begin
            n_err++;
            $display("FAIL signed_m1: got res=%h avg=%h, want 0ff0 ff", r[1], a[1]);
        end
        run_block({32'h0, 32'h0, 32'h0, 32'h00000008}, 1, seen, lat, extra, r, a);
        n_vec++;
        if (!seen || r[0] !== 16'd8 || a[0] !== 8'd1 || r[2] !== 16'd8 || a[2] !== 8'd0) begin
            n_err++;
            $display("FAIL round8: got res=%0d/%0d avg=%0d/%0d, want 8/8 1/0", r[0], r[2], a[0], a[2]);
        end
        run_block({32'h0, 32'h0, 32'h0, 32'h000000F8}, 0, seen, lat, extra, r, a);
        n_vec++;
        if (!seen || r[1] !== 16'h0FF8 || a[1] !== 8'd0) begin
            n_err++;
            $display("FAIL signed_m8: got res=%h avg=%h, want 0ff8 00", r[1], a[1]);
        end
    endtask

    task automatic test_clr();
        bit seen; int lat, extra;
        logic [2:0][15:0] r; logic [2:0][7:0] a;
        apply(1'b1, $urandom, 1'b0, 1'b1);
        apply(1'b1, $urandom, 1'b0, 1'b1);
        run_block({4{32'h02020202}}, 0, seen, lat, extra, r, a);
        n_vec++;
        if (!seen || extra != 0 || r[0] !== 16'd32 || a[0] !== 8'd2) begin
            n_err++;
            $display("FAIL clr_flush: got seen=%b extra=%0d res=%0d avg=%0d, want 1 0 32 2", seen, extra, r[0], a[0]);
        end
    endtask

    task automatic test_clr_final();
        int pulses = 0;
        apply(1'b0, 32'h0, 1'b1, 1'b1);
        for (int b = 0; b < 4; b++) apply(1'b1, $urandom, 1'b0, 1'b1);
        apply(1'b0, $urandom, 1'b0, 1'b1);
        apply(1'b0, $urandom, 1'b0, 1'b1);
        apply(1'b0, $urandom, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, $urandom, 1'b0, 1'b1);
            if (rv[0] === 1'b1) pulses++;
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (rv[d] !== chk_val[d] || rs[d] !== 16'(chk_res[d] & wmask(d)) || av[d] !== 8'(chk_avg[d]) || cn[d] !== 3'(chk_cnt[d])) begin
                    n_err++;
                    $display("FAIL clr_final dut%0d cyc=%0d: got val=%b res=%h avg=%h cnt=%0d, want val=%b res=%h avg=%h cnt=%0d",
                             d, i, rv[d], rs[d], av[d], cn[d], chk_val[d], 16'(chk_res[d] & wmask(d)), 8'(chk_avg[d]), chk_cnt[d]);
                end
            end
        end
        n_vec++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL clr_final_pulse: got %0d pulses, want 0", pulses);
        end
    endtask

    task automatic test_reset_mid_block();
        bit seen; int lat, extra;
        logic [2:0][15:0] r; logic [2:0][7:0] a;
        apply(1'b0, 32'h0, 1'b1, 1'b1);
        apply(1'b1, $urandom, 1'b0, 1'b1);
        apply(1'b1, $urandom, 1'b0, 1'b1);
        apply(1'b0, 32'h0, 1'b0, 1'b0);
        apply(1'b0, $urandom, 1'b0, 1'b1);
        for (int d = 0; d < 4; d++) begin
            n_vec++;
            if (rv[d] !== 1'b0 || rs[d] !== 16'h0 || av[d] !== 8'h0 || cn[d] !== 3'h0) begin
                n_err++;
                $display("FAIL reset_mid dut%0d: got val=%b res=%h avg=%h cnt=%0d, want all 0", d, rv[d], rs[d], av[d], cn[d]);
            end
        end
        run_block({4{32'h03030303}}, 0, seen, lat, extra, r, a);
        n_vec++;
        if (!seen || extra != 0 || r[0] !== 16'd48 || a[0] !== 8'd3) begin
            n_err++;
            $display("FAIL after_reset: got seen=%b extra=%0d res=%0d avg=%0d, want 1 0 48 3", seen, extra, r[0], a[0]);
        end
    endtask

    task automatic test_k0();
        int lat = -1;
        int pulses = 0;
        logic [15:0] r = 16'h0;
        logic [7:0]  a = 8'h0;
        apply(1'b0, 32'h0, 1'b1, 1'b1);
        apply(1'b1, 32'h04030201, 1'b0, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            apply(1'b0, $urandom, 1'b0, 1'b1);
            if (rv[3] === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = c - 1;
                    r = rs[3];
                    a = av[3];
                end
            end
        end
        n_vec++;
        if (pulses != 1 || lat != TN + 1 || r !== 16'd10 || a !== 8'd3) begin
            n_err++;
            $display("FAIL k0_single: got pulses=%0d lat=%0d res=%0d avg=%0d, want 1 3 10 3", pulses, lat, r, a);
        end
    endtask

    task automatic test_random();
        logic v, c;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 39) == 0);
            apply(v, $urandom, c, 1'b1);
            for (int d = 0; d < 4; d++) begin
                n_vec++;
                if (rv[d] !== chk_val[d] || rs[d] !== 16'(chk_res[d] & wmask(d)) || av[d] !== 8'(chk_avg[d]) || cn[d] !== 3'(chk_cnt[d])) begin
                    n_err++;
                    $display("FAIL random dut%0d cyc=%0d: got val=%b res=%h avg=%h cnt=%0d, want val=%b res=%h avg=%h cnt=%0d",
                             d, i, rv[d], rs[d], av[d], cn[d], chk_val[d], 16'(chk_res[d] & wmask(d)), 8'(chk_avg[d]), chk_cnt[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_plan_blocks();
        test_clr();
        test_clr_final();
        test_reset_mid_block();
        test_k0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qnigma_avg.md
Name: qnigma_avg

Overview:
Streaming block averager. Each valid beat carries 2**N parallel lanes, which a pipelined, valid-tracked adder tree reduces to one sum. A sequential accumulator then sums 2**K such beats. Once per block it emits the full-precision sum and a rounded W-bit average. Used in the math path wherever multi-lane samples need decimating and averaging over time.

Parameters:
W, 8, lane sample width in bits
N, 2, log2 of the lane count per beat; N >= 1
K, 2, log2 of the beats accumulated per output; K >= 0
SIGNED, 0, 1 = lanes and results are two's complement; 0 = unsigned
ROUND, 1, 1 = round half up on the average; 0 = truncate (floor)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
clr  in  1  synchronous flush of the tree valids, beat counter and accumulator
in_val  in  1  input beat valid
in_dat  in  [2**N-1:0][W-1:0]  lane samples
res_val  out  1  one-cycle pulse; res and avg are valid
res  out  W+N+K  full-precision sum of 2**(N+K) samples
avg  out  W  res divided by 2**(N+K), rounded per ROUND
cnt  out  K+1  beats accumulated in the current block; for visibility only

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - res_val=0, res=0, avg=0, cnt=0.
  - All tree valid flags and the accumulator are cleared.
  - Tree data registers need not be reset.
- Tree:
  - N registered stages; each stage adds pairs at width +1.
  - Sign-extended when SIGNED=1, zero-extended otherwise.
  - Valid travels with the data, one flag per stage.
  - A beat sampled at edge t gives its tree sum, tree_val=1, at edge t+N.
  - Holes in in_val are allowed; there is no backpressure. in_dat is don't-care while in_val=0.
- Accumulator (on tree_val):
  - If cnt==0, acc = tree sum; otherwise acc = acc + tree sum. Then cnt++.
  - When cnt reaches 2**K-1 and tree_val=1: register res = acc_next and avg = round(acc_next); pulse res_val for exactly 1 cycle; set cnt=0.
  - End-to-end latency: last beat of a block sampled at edge t -> res_val at edge t+N+1.
  - K=0: every beat produces an output, latency N+1.
- res and avg hold their values between pulses.
- Widths: W+N+K bits cannot overflow. Internal arithmetic uses no wrap.
- Average:
  - ROUND=1: avg = (res + 2**(N+K-1)) >>> (N+K). Use one guard bit; the result always fits W bits, so no saturation is needed.
  - ROUND=0: avg = res >>> (N+K).
  - The shift is arithmetic when SIGNED=1, logical otherwise.
- clr:
  - At the same edge: tree valids=0, cnt=0, acc=0, res_val=0. res and avg hold their values.
  - in_val asserted in the same cycle as clr is discarded.
  - Beats already in flight are dropped; the first beat after clr starts a new block.
- Simultaneous clr and a final tree_val: clr wins and no output is produced.
- Reset mid-block: the partial block is discarded, identical to clr except outputs go to 0.
- No state machine beyond the cnt counter and the valid shift chain.

Decomposition:
- Package qnigma_math_pkg holds:
  - sum width function sumw(W,N,K) = W+N+K;
  - the sign-extend helper;
  - the round-shift helper, parameterised by SIGNED and ROUND.
- Sub-module qnigma_sum_tree:
  - the recursive valid-carrying pipelined adder tree;
  - parameters W, N, SIGNED; ports clk, rst_n, clr, in_val, in_dat, out_val, out_sum (W+N).
- Top level: accumulator, counter and output registers.

Test Plan (W=8, N=2, K=2 unless stated):
- Unsigned, 4 consecutive beats, all lanes 8'd1 -> one res_val pulse 3 cycles after the last beat; res=12'd16, avg=8'd1; cnt walks 0,1,2,3,0.
- Unsigned, all lanes 8'd255 for 4 beats, with idle cycles between beats -> res=12'd4080, avg=8'd255; exactly one pulse.
- Rounding: lane sum 8 over the block (one lane = 8, rest 0):
  - ROUND=1 -> avg=1;
  - ROUND=0 -> avg=0;
  - res=16'd8 in both cases.
- SIGNED=1: all lanes 8'hFF for 4 beats -> res=12'hFF0 (-16), avg=8'hFF (-1). Second case: lane sum -8 with ROUND=1 -> avg=0 (half up).
- clr: assert clr after 2 beats, then send 4 beats of 8'd2 -> the single output is res=32, avg=2. Also check that clr coincident with the block-final tree_val produces no pulse.
- rst_n low mid-block: all outputs go to 0. A following full block of 8'd3 -> res=48, avg=3. K=0 variant: every beat pulses, N+1 latency.
